// File: rtl/switch_box_config_loader.sv
// -----------------------------------------------------------------------------
// switch_box_config_loader
//
// Serial configuration loader for the disjoint switch box. A frame is opened
// by cfg_start, followed by N = W*6 configuration bits (frame bit j ends up on
// c[j]) and one even-parity trailer bit. Only a frame whose parity checks is
// copied onto c, and all N bits of c change on the same edge. A frame with a
// bad trailer sets the sticky err flag and leaves c untouched.
//
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset (also clears c)
//   cfg_start  in  1  begin / restart a frame (ignored in CHECK)
//   cfg_valid  in  1  cfg_bit is valid this cycle
//   cfg_bit    in  1  serial data / parity bit
//   cfg_ready  out 1  bit is accepted when cfg_valid & cfg_ready
//   c          out N  active switch configuration
//   busy       out 1  state is not IDLE
//   done       out 1  one-cycle pulse on commit
//   err        out 1  sticky parity error, cleared by the next start
// -----------------------------------------------------------------------------
module switch_box_config_loader #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic [W*6-1:0]   c,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int N  = W * 6;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, PARITY, CHECK} state_e;

    state_e          state_q;
    logic [N-1:0]    shadow_q;
    logic [N-1:0]    c_q;
    logic [CW-1:0]   cnt_q;
    logic            acc_q;
    logic            pok_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic            accept;
    logic            restart;

    assign accept  = cfg_valid & ready_q;
    // A start wins over a simultaneous accept; CHECK always runs to completion.
    assign restart = cfg_start & (state_q != CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            pok_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (restart) begin
                state_q <= LOAD;
                cnt_q   <= '0;
                acc_q   <= 1'b0;
                err_q   <= 1'b0;
                ready_q <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (accept) begin
                            // Shift in from the top so the first bit lands at c[0].
                            shadow_q <= {cfg_bit, shadow_q[N-1:1]};
                            acc_q    <= acc_q ^ cfg_bit;
                            cnt_q    <= cnt_q + 1'b1;
                            if (cnt_q == CW'(N - 1))
                                state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (accept) begin
                            pok_q   <= ~(acc_q ^ cfg_bit);
                            state_q <= CHECK;
                            ready_q <= 1'b0;
                        end
                    end
                    CHECK: begin
                        if (pok_q) begin
                            c_q    <= shadow_q;
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: ;  // IDLE: wait for start, cfg_valid ignored
                endcase
            end
        end
    end

    assign cfg_ready = ready_q;
    assign c         = c_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_switch_box_config_loader.sv
// -----------------------------------------------------------------------------
// Testbench for switch_box_config_loader (W = 8, N = 48).
// Inputs change right after the falling edge; outputs are sampled at the
// falling edge, i.e. half a cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_switch_box_config_loader;
    localparam int W = 8;
    localparam int N = W * 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_ready;
    logic [N-1:0]  c;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    switch_box_config_loader #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         bad_par;
        int           stall_pct;
        logic [N-1:0] exp_c;
        logic         exp_done;
        logic         exp_err;
    } frame_t;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Open a frame: start is sampled at the next rising edge.
    task automatic do_start();
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Stream the first nbits of {parity, data} LSB first; c must not move.
    task automatic stream(input logic [N-1:0] d, input logic bad, input int stall_pct,
                          input int nbits, input logic [N-1:0] old_c);
        int i = 0;
        int budget = 2000;
        logic v;
        while (i < nbits && budget > 0) begin
            chk("ready_in_frame", {47'b0, cfg_ready}, 48'd1);
            chk("busy_in_frame", {47'b0, busy}, 48'd1);
            chk("c_hold_in_frame", c, old_c);
            chk("err_clear_in_frame", {47'b0, err}, 48'd0);
            v = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            cfg_valid = v;
            cfg_bit   = (i < N) ? d[i] : ((^d) ^ bad);
            @(negedge clk);
            if (v) i++;
            budget--;
        end
        cfg_valid = 1'b0;
        if (i < nbits) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_budget: sent %0d bits required %0d", i, nbits);
        end
    endtask

    // Called at the falling edge right after the parity accept (CHECK state).
    // cfg_valid is held high to show it is ignored in CHECK and IDLE.
    task automatic finish(input logic [N-1:0] old_c, input logic [N-1:0] exp_c,
                          input logic exp_done, input logic exp_err);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        chk("check_c_hold", c, old_c);
        chk("check_done_low", {47'b0, done}, 48'd0);
        chk("check_ready_low", {47'b0, cfg_ready}, 48'd0);
        chk("check_busy_high", {47'b0, busy}, 48'd1);
        @(negedge clk);
        chk("commit_c", c, exp_c);
        chk("commit_done", {47'b0, done}, {47'b0, exp_done});
        chk("commit_err", {47'b0, err}, {47'b0, exp_err});
        chk("commit_busy_low", {47'b0, busy}, 48'd0);
        @(negedge clk);
        chk("post_done_low", {47'b0, done}, 48'd0);
        chk("post_ready_low", {47'b0, cfg_ready}, 48'd0);
        chk("post_c", c, exp_c);
        repeat (3) @(negedge clk);
        chk("idle_err_sticky", {47'b0, err}, {47'b0, exp_err});
        chk("idle_c", c, exp_c);
        chk("idle_busy", {47'b0, busy}, 48'd0);
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    frame_t tbl[5];
    logic [N-1:0] cur_c;

    initial begin
        tbl[0] = '{48'hA5A5_0F0F_1234, 1'b0,  0, 48'hA5A5_0F0F_1234, 1'b1, 1'b0};
        tbl[1] = '{48'h0000_0000_0001, 1'b0,  0, 48'h0000_0000_0001, 1'b1, 1'b0};
        tbl[2] = '{48'hFFFF_FFFF_FFFF, 1'b1,  0, 48'h0000_0000_0001, 1'b0, 1'b1};
        tbl[3] = '{48'hA5A5_0F0F_1234, 1'b0, 50, 48'hA5A5_0F0F_1234, 1'b1, 1'b0};
        tbl[4] = '{48'h8000_0000_0003, 1'b1, 30, 48'hA5A5_0F0F_1234, 1'b0, 1'b1};

        // Reset held with random inputs.
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge clk);
            cfg_start = 1'($urandom);
            cfg_valid = 1'($urandom);
            cfg_bit   = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_c", c, 48'd0);
        chk("rst_ready", {47'b0, cfg_ready}, 48'd0);
        chk("rst_busy", {47'b0, busy}, 48'd0);
        chk("rst_done", {47'b0, done}, 48'd0);
        chk("rst_err", {47'b0, err}, 48'd0);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        rst_n     = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_c", c, 48'd0);
        chk("idle_ready", {47'b0, cfg_ready}, 48'd0);
        chk("idle_busy", {47'b0, busy}, 48'd0);
        chk("idle_done", {47'b0, done}, 48'd0);
        chk("idle_err", {47'b0, err}, 48'd0);

        // Table of whole frames: good, bad parity, stalled.
        cur_c = 48'd0;
        for (int k = 0; k < 5; k++) begin
            do_start();
            stream(tbl[k].data, tbl[k].bad_par, tbl[k].stall_pct, N + 1, cur_c);
            finish(cur_c, tbl[k].exp_c, tbl[k].exp_done, tbl[k].exp_err);
            cur_c = tbl[k].exp_c;
        end

        // Abort: start together with a valid bit drops that bit and restarts.
        do_start();
        stream(48'h1234_5678_9ABC, 1'b0, 0, 20, cur_c);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("abort_c_hold", c, cur_c);
        chk("abort_busy", {47'b0, busy}, 48'd1);
        stream(48'h0000_0000_FFFF, 1'b0, 0, N + 1, cur_c);
        finish(cur_c, 48'h0000_0000_FFFF, 1'b1, 1'b0);
        cur_c = 48'h0000_0000_FFFF;

        // Start during CHECK is ignored: the frame still commits and ends IDLE.
        do_start();
        stream(48'h0000_0000_0001, 1'b0, 0, N + 1, cur_c);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("chk_start_c", c, 48'h0000_0000_0001);
        chk("chk_start_done", {47'b0, done}, 48'd1);
        chk("chk_start_busy", {47'b0, busy}, 48'd0);
        cur_c = 48'h0000_0000_0001;
        repeat (2) @(negedge clk);

        // Reset mid-frame clears c immediately, between clock edges.
        do_start();
        stream(48'hFFFF_0000_FFFF, 1'b0, 0, 30, cur_c);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_c", c, 48'd0);
        chk("midrst_busy", {47'b0, busy}, 48'd0);
        chk("midrst_ready", {47'b0, cfg_ready}, 48'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        repeat (10) begin
            cfg_valid = 1'($urandom);
            cfg_bit   = 1'($urandom);
            @(negedge clk);
            chk("post_rst_c", c, 48'd0);
            chk("post_rst_busy", {47'b0, busy}, 48'd0);
            chk("post_rst_ready", {47'b0, cfg_ready}, 48'd0);
        end
        cfg_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
